// File: rtl/mem_sweep_pkg.sv
// Shared types and constants for the memory sweep sequencer.
package mem_sweep_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    localparam logic OP_FILL   = 1'b0;
    localparam logic OP_VERIFY = 1'b1;

endpackage

// File: rtl/mem_sweep_check.sv
// Read-back checker: registers the expected word and address of each read,
// compares one cycle later, keeps sticky error state (err_count under MEM_SWEEP_ERR_CNT_EN).
module mem_sweep_check
    import mem_sweep_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              clr_err,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_exp,
    input  logic [DATA_W-1:0] rdata,
`ifdef MEM_SWEEP_ERR_CNT_EN
    output logic [ADDR_W:0]   err_count,
`endif
    output logic              error,
    output logic [ADDR_W-1:0] err_addr
);

    logic              pend_q, pend_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              error_q, error_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic              mismatch;

    assign mismatch = pend_q && (rdata != exp_q);

`ifdef MEM_SWEEP_ERR_CNT_EN
    logic [ADDR_W:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (clr_err)
            err_count_d = '0;
        else if (mismatch && (err_count_q != '1))
            err_count_d = err_count_q + {{ADDR_W{1'b0}}, 1'b1};
    end

    always_ff @(posedge clock) begin
        if (!clear)
            err_count_q <= '0;
        else
            err_count_q <= err_count_d;
    end

    assign err_count = err_count_q;
`endif

    always_comb begin
        pend_d     = rd_en;
        exp_d      = rd_exp;
        addr_d     = rd_addr;
        error_d    = error_q;
        err_addr_d = err_addr_q;
        if (clr_err) begin
            error_d    = 1'b0;
            err_addr_d = '0;
        end else if (mismatch) begin
            error_d = 1'b1;
            // only the first mismatch of a sweep is reported
            if (!error_q)
                err_addr_d = addr_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            pend_q     <= 1'b0;
            exp_q      <= '0;
            addr_q     <= '0;
            error_q    <= 1'b0;
            err_addr_q <= '0;
        end else begin
            pend_q     <= pend_d;
            exp_q      <= exp_d;
            addr_q     <= addr_d;
            error_q    <= error_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign error    = error_q;
    assign err_addr = err_addr_q;

endmodule

// File: rtl/mem_sweep_ctrl.sv
// Fill / verify sweep sequencer driving an external address counter and memory.
// Optional err_count output when MEM_SWEEP_ERR_CNT_EN is defined.
module mem_sweep_ctrl
    import mem_sweep_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic              op_verify,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic [DATA_W-1:0] pattern,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] err_addr,
`ifdef MEM_SWEEP_ERR_CNT_EN
    output logic [ADDR_W:0]   err_count,
`endif
    output logic              cnt_load,
    output logic              cnt_enable,
    output logic              cnt_tick,
    output logic              cnt_up,
    output logic [ADDR_W-1:0] cnt_load_data,
    input  logic [ADDR_W-1:0] cnt_value,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state_q, state_d;
    logic              dir_q, dir_d;
    logic              verify_q, verify_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [DATA_W-1:0] pattern_q, pattern_d;
    logic [DATA_W-1:0] exp_data;
    logic              accept;
    logic              at_end;

    // a start coinciding with reset must not disturb the counter
    assign accept   = clear && start && (state_q == ST_IDLE);
    assign at_end   = (cnt_value == end_q);
    assign exp_data = pattern_q ^ DATA_W'(cnt_value);

    always_comb begin
        state_d       = state_q;
        dir_d         = dir_q;
        verify_d      = verify_q;
        end_d         = end_q;
        pattern_d     = pattern_q;
        cnt_load      = 1'b0;
        cnt_enable    = 1'b0;
        cnt_tick      = 1'b0;
        cnt_up        = 1'b0;
        cnt_load_data = '0;
        mem_we        = 1'b0;
        mem_re        = 1'b0;
        mem_wdata     = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_load      = 1'b1;
                    cnt_tick      = 1'b1;
                    cnt_load_data = start_addr;
                    dir_d         = (end_addr >= start_addr);
                    verify_d      = op_verify;
                    end_d         = end_addr;
                    pattern_d     = pattern;
                    state_d       = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_up = dir_q;
                if (verify_q == OP_VERIFY) begin
                    mem_re = 1'b1;
                end else begin
                    mem_we    = 1'b1;
                    mem_wdata = exp_data;
                end
                if (!at_end) begin
                    cnt_enable = 1'b1;
                    cnt_tick   = 1'b1;
                end else begin
                    state_d = (verify_q == OP_VERIFY) ? ST_DRAIN : ST_DONE;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q   <= ST_IDLE;
            dir_q     <= 1'b0;
            verify_q  <= OP_FILL;
            end_q     <= '0;
            pattern_q <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            verify_q  <= verify_d;
            end_q     <= end_d;
            pattern_q <= pattern_d;
        end
    end

    assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done     = (state_q == ST_DONE);
    assign mem_addr = cnt_value;

    mem_sweep_check #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_check (
        .clock     (clock),
        .clear     (clear),
        .clr_err   (accept),
        .rd_en     (mem_re),
        .rd_addr   (cnt_value),
        .rd_exp    (exp_data),
        .rdata     (mem_rdata),
`ifdef MEM_SWEEP_ERR_CNT_EN
        .err_count (err_count),
`endif
        .error     (error),
        .err_addr  (err_addr)
    );

endmodule

// File: tb/tb_mem_sweep_ctrl.sv
// Bench for mem_sweep_ctrl with a behavioural counter, memory and sweep model.
module tb_mem_sweep_ctrl;

    logic       clock = 1'b0;
    logic       clear = 1'b0;
    logic       start = 1'b0;
    logic       op_verify = 1'b0;
    logic [7:0] start_addr = '0;
    logic [7:0] end_addr = '0;
    logic [7:0] pattern = '0;
    logic       busy, done, error;
    logic [7:0] err_addr;
    logic       cnt_load, cnt_enable, cnt_tick, cnt_up;
    logic [7:0] cnt_load_data;
    logic [7:0] cnt_value = '0;
    logic [7:0] mem_addr;
    logic       mem_we, mem_re;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = '0;
`ifdef MEM_SWEEP_ERR_CNT_EN
    logic [8:0] err_count;
`endif

    logic       poke_en = 1'b0;
    logic [7:0] poke_addr = '0;
    logic [7:0] poke_data = '0;
    logic [7:0] mem [256];

    logic [7:0] log_a [$];
    logic [7:0] log_d [$];
    logic       log_w [$];
    logic       log_up [$];

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       op;
        logic [7:0] s;
        logic [7:0] e;
        logic [7:0] p;
        logic       cor;
        logic [7:0] ca;
        logic [7:0] cd;
        logic       xerr;
        logic [7:0] xea;
        int         xlat;
    } vec_t;

    vec_t vt [6];

    always #5 clock = ~clock;

    mem_sweep_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
        .clock         (clock),
        .clear         (clear),
        .start         (start),
        .op_verify     (op_verify),
        .start_addr    (start_addr),
        .end_addr      (end_addr),
        .pattern       (pattern),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .err_addr      (err_addr),
`ifdef MEM_SWEEP_ERR_CNT_EN
        .err_count     (err_count),
`endif
        .cnt_load      (cnt_load),
        .cnt_enable    (cnt_enable),
        .cnt_tick      (cnt_tick),
        .cnt_up        (cnt_up),
        .cnt_load_data (cnt_load_data),
        .cnt_value     (cnt_value),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_re        (mem_re),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    always @(posedge clock) begin
        if (cnt_tick) begin
            if (cnt_load)
                cnt_value <= cnt_load_data;
            else if (cnt_enable)
                cnt_value <= cnt_up ? cnt_value + 8'd1 : cnt_value - 8'd1;
        end
    end

    always @(posedge clock) begin
        if (poke_en)
            mem[poke_addr] <= poke_data;
        else if (mem_we)
            mem[mem_addr] <= mem_wdata;
        if (mem_re)
            mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clock);
        poke_en = 1'b1;
        poke_addr = a;
        poke_data = d;
        @(negedge clock);
        poke_en = 1'b0;
    endtask

    // Reference: walk the range in sweep order against the memory contents.
    task automatic model_verify(input logic [7:0] s, input logic [7:0] e, input logic [7:0] p,
                                output logic err, output logic [7:0] ea, output int cnt);
        logic [7:0] a;
        a = s;
        err = 1'b0;
        ea = '0;
        cnt = 0;
        forever begin
            if (mem[a] !== (p ^ a)) begin
                if (!err) ea = a;
                err = 1'b1;
                cnt++;
            end
            if (a == e) break;
            a = (e >= s) ? a + 8'd1 : a - 8'd1;
        end
        if (cnt > 511) cnt = 511;
    endtask

    task automatic run_sweep(input logic op, input logic [7:0] s, input logic [7:0] e,
                             input logic [7:0] p, input int glitch,
                             output int lat, output logic err, output logic [7:0] ea);
        log_a.delete();
        log_d.delete();
        log_w.delete();
        log_up.delete();
        lat = 0;
        err = 1'b0;
        ea = '0;
        @(negedge clock);
        start = 1'b1;
        op_verify = op;
        start_addr = s;
        end_addr = e;
        pattern = p;
        #1;
        chk("load_ctrl", {29'd0, cnt_load, cnt_tick, cnt_enable}, 32'd6);
        chk("load_data", cnt_load_data, s);
        @(posedge clock);
        #1;
        start = 1'b0;
        op_verify = ~op;
        end_addr = ~e;
        pattern = ~p;
        for (int i = 1; i <= 600; i++) begin
            @(negedge clock);
            if (i == 1) begin
                chk("err_clr_on_start", error, 0);
                chk("busy_run", busy, 1);
            end
            if (mem_we || mem_re) begin
                log_a.push_back(mem_addr);
                log_d.push_back(mem_wdata);
                log_w.push_back(mem_we);
                log_up.push_back(cnt_up);
            end
            if (done) begin
                lat = i;
                err = error;
                ea = err_addr;
                chk("busy_at_done", busy, 0);
                break;
            end
            start = (i == glitch);
            start_addr = (i == glitch) ? 8'h80 : s;
        end
        start = 1'b0;
    endtask

    task automatic check_trace(input logic op, input logic [7:0] s, input logic [7:0] e,
                               input logic [7:0] p);
        logic [7:0] a;
        logic       up;
        int         n;
        a = s;
        up = (e >= s);
        n = 0;
        forever begin
            if (n < log_a.size()) begin
                chk("addr", log_a[n], a);
                chk("strobe_we", log_w[n], !op);
                chk("cnt_up", log_up[n], up);
                if (!op) chk("wdata", log_d[n], p ^ a);
            end
            n++;
            if (a == e) break;
            a = up ? a + 8'd1 : a - 8'd1;
        end
        chk("n_access", log_a.size(), n);
    endtask

    task automatic do_sweep(input logic op, input logic [7:0] s, input logic [7:0] e,
                            input logic [7:0] p, input int glitch, input bit idle_after,
                            output logic err, output logic [7:0] ea, output int lat);
        logic       m_err;
        logic [7:0] m_ea;
        int         m_cnt;
        int         n;
        n = (e >= s) ? e - s + 1 : s - e + 1;
        m_err = 1'b0;
        m_ea = '0;
        m_cnt = 0;
        if (op) model_verify(s, e, p, m_err, m_ea, m_cnt);
        run_sweep(op, s, e, p, glitch, lat, err, ea);
        chk("latency", lat, op ? n + 2 : n + 1);
        chk("error", err, m_err);
        chk("err_addr", ea, m_ea);
`ifdef MEM_SWEEP_ERR_CNT_EN
        chk("err_count", err_count, m_cnt);
`endif
        check_trace(op, s, e, p);
        if (idle_after) begin
            repeat (2) @(negedge clock);
            chk("err_sticky", error, m_err);
            chk("done_one_cycle", done, 0);
        end
    endtask

    initial begin
        logic       r_err;
        logic [7:0] r_ea;
        int         r_lat;
        logic [7:0] s, e, lo, hi;
        int         d;
        bit         seen;

        vt[0] = '{1'b0, 8'h10, 8'h13, 8'hA5, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 5};
        vt[1] = '{1'b1, 8'h10, 8'h13, 8'hA5, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 6};
        vt[2] = '{1'b1, 8'h10, 8'h13, 8'hA5, 1'b1, 8'h12, 8'h00, 1'b1, 8'h12, 6};
        vt[3] = '{1'b0, 8'h05, 8'h02, 8'h3C, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 5};
        vt[4] = '{1'b0, 8'hFF, 8'hFF, 8'h11, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 2};
        vt[5] = '{1'b1, 8'hFF, 8'hFF, 8'h11, 1'b1, 8'hFF, 8'h00, 1'b1, 8'hFF, 3};

        clear = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_err_addr", err_addr, 0);
        chk("rst_strobes", {mem_we, mem_re}, 0);
        chk("rst_cnt_ctrl", {cnt_load, cnt_enable, cnt_tick, cnt_up}, 0);
        clear = 1'b1;

        for (int i = 0; i < 6; i++) begin
            if (vt[i].cor) poke(vt[i].ca, vt[i].cd);
            do_sweep(vt[i].op, vt[i].s, vt[i].e, vt[i].p, 0, 1'b1, r_err, r_ea, r_lat);
            chk("vec_error", r_err, vt[i].xerr);
            chk("vec_err_addr", r_ea, vt[i].xea);
            chk("vec_latency", r_lat, vt[i].xlat);
        end

        // reset in IDLE wipes sticky error state
        @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
        clear = 1'b1;
        chk("rst_idle_error", error, 0);
        chk("rst_idle_err_addr", err_addr, 0);

        // reset asserted in the third RUN cycle
        @(negedge clock);
        start = 1'b1;
        op_verify = 1'b0;
        start_addr = 8'h40;
        end_addr = 8'h50;
        pattern = 8'h00;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (3) @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
        chk("midrst_busy", busy, 0);
        chk("midrst_strobes", {mem_we, mem_re}, 0);
        chk("midrst_cnt_ctrl", {cnt_load, cnt_enable, cnt_tick, cnt_up}, 0);
        clear = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clock);
            if (done) seen = 1'b1;
        end
        chk("midrst_no_done", seen, 0);

        // start pulsed mid-sweep must be ignored
        do_sweep(1'b0, 8'h20, 8'h27, 8'h66, 3, 1'b1, r_err, r_ea, r_lat);

        // randomized back-to-back fill then verify with random corruption
        for (int it = 0; it < 12; it++) begin
            s = 8'($urandom);
            d = $urandom_range(30, 0);
            if ($urandom_range(1, 0) == 1)
                e = (int'(s) + d > 255) ? 8'hFF : 8'(int'(s) + d);
            else
                e = (int'(s) < d) ? 8'h00 : 8'(int'(s) - d);
            lo = (s < e) ? s : e;
            hi = (s < e) ? e : s;
            do_sweep(1'b0, s, e, 8'($urandom), 0, 1'b0, r_err, r_ea, r_lat);
            do_sweep(1'b1, s, e, pattern ^ 8'hFF, 0, 1'b0, r_err, r_ea, r_lat);
            repeat ($urandom_range(2, 0))
                poke(8'($urandom_range(int'(hi), int'(lo))), 8'($urandom));
            do_sweep(1'b1, s, e, ~pattern, 0, 1'b1, r_err, r_ea, r_lat);
        end

`ifdef MEM_SWEEP_ERR_CNT_EN
        do_sweep(1'b0, 8'h30, 8'h3F, 8'h5A, 0, 1'b1, r_err, r_ea, r_lat);
        poke(8'h31, 8'h00);
        poke(8'h35, 8'h00);
        poke(8'h3E, 8'h00);
        do_sweep(1'b1, 8'h30, 8'h3F, 8'h5A, 0, 1'b0, r_err, r_ea, r_lat);
        chk("err_count_3", err_count, 3);
        do_sweep(1'b0, 8'h00, 8'hFF, 8'h00, 0, 1'b0, r_err, r_ea, r_lat);
        do_sweep(1'b1, 8'h00, 8'hFF, 8'hFF, 0, 1'b0, r_err, r_ea, r_lat);
        chk("err_count_256", err_count, 256);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_sweep_ctrl.md
# mem_sweep_ctrl

Sequencer that drives a LogisimCounter address counter and a single-port synchronous memory to fill an address range with a pattern, or to read it back and verify it. It sits directly upstream of the counter: it drives the counter's load, enable, tick and direction, and consumes its count value as the memory address. Used for memory init and self-test in the HW2 memory datapath.

## Interface
- ADDR_W, 8, address and counter width; the counter instance uses width=ADDR_W, mode=0, invertClock=0.
- DATA_W, 8, memory data width.
- clock  input  1  system clock; all state changes on the rising edge.
- clear  input  1  reset, synchronous, active-low.
- start  input  1  begin a sweep; sampled only in IDLE.
- op_verify  input  1  0 = fill, 1 = verify; latched at start.
- start_addr  input  ADDR_W  first address.
- end_addr  input  ADDR_W  last address, inclusive; latched at start.
- pattern  input  DATA_W  data seed; latched at start.
- busy  output  1  high while in RUN or DRAIN.
- done  output  1  one-cycle pulse when the sweep completes.
- error  output  1  sticky verify mismatch flag; cleared by the next accepted start.
- err_addr  output  ADDR_W  address of the first mismatch.
- cnt_load, cnt_enable, cnt_tick, cnt_up  output  1 each  counter controls.
- cnt_load_data  output  ADDR_W  counter load value.
- cnt_value  input  ADDR_W  counter countValue.
- mem_addr  output  ADDR_W  memory address; equals cnt_value.
- mem_we, mem_re  output  1  write strobe and read strobe.
- mem_wdata  output  DATA_W  write data.
- mem_rdata  input  DATA_W  read data, valid exactly 1 cycle after mem_re.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - When start=1: drive cnt_load=1, cnt_tick=1, cnt_load_data=start_addr (combinational, same cycle).
  - Latch end_addr, op_verify and pattern. Latch dir_q = (end_addr >= start_addr), unsigned compare.
  - Clear error, err_addr and the optional counter. Go to RUN.
- RUN:
  - Expected data is exp = pattern_q XOR cnt_value, with the address zero-extended or truncated to DATA_W.
  - Fill: mem_we=1, mem_wdata=exp. Verify: mem_re=1, and register exp and the address for the next-cycle compare.
  - cnt_up=dir_q.
  - When cnt_value != end_q: cnt_enable=1 and cnt_tick=1.
  - When cnt_value == end_q: perform the last access with no tick. Fill goes to DONE; verify goes to DRAIN.
- DRAIN: compare the final read. No memory strobe. Go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- Verify compare: it runs in every cycle after a RUN read, including DRAIN.
  - On mismatch, set error.
  - If this is the first mismatch, load err_addr with the registered address.
- Counter controls are 0 outside the cases listed above.
- Boundaries:
  - start_addr == end_addr: exactly one access.
  - Descending ranges count down.
  - Ranges never wrap through 0 or 2^ADDR_W-1; direction is chosen so the end is always reached.
- start outside IDLE is ignored.

## Timing
- Reset (clear=0 at an edge):
  - State returns to IDLE.
  - busy, done, error, all strobes and all counter controls = 0; err_addr = 0.
  - Applies mid-sweep; the counter value is left as-is.
- Start accepted at edge k. RUN covers cycles k+1 .. k+N, where N = |end-start|+1. mem_addr in cycle k+i is start ± (i-1).
- Fill: done is high in cycle k+N+1.
- Verify: DRAIN in k+N+1, done in k+N+2. error is valid when done is high.
- A new start is accepted in the cycle after done (back-to-back sweeps allowed).

## Configuration
- MEM_SWEEP_ERR_CNT_EN defined: adds output err_count, width ADDR_W+1.
  - Counts mismatches in verify mode, saturating at all-ones.
  - Cleared on an accepted start and on reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Package mem_sweep_pkg holds:
  - the state typedef (IDLE, RUN, DRAIN, DONE);
  - OP_FILL=0 and OP_VERIFY=1 constants.
- Sub-module mem_sweep_check holds the registered expected data and address, the compare, and the sticky error, err_addr and optional err_count.
- The FSM stays in mem_sweep_ctrl. The counter is instantiated beside it by the parent, not inside.

## Test plan
- Fill, start=0x10, end=0x13, pattern=0xA5: writes at 0x10..0x13 of 0xB5, 0xB4, 0xB7, 0xB6. done is high at k+5.
- Verify the same range against a correct memory: reads at 0x10..0x13, error=0, done at k+6.
- Verify with memory[0x12] corrupted to 0x00: error=1 and err_addr=0x12 at done, stays set in IDLE, and clears on the next start.
- Descending fill, start=0x05, end=0x02: cnt_up=0, addresses 0x05, 0x04, 0x03, 0x02. Single address (start=end=0xFF): one write, done at k+2.
- clear=0 in the third RUN cycle: busy and strobes are 0 next cycle, and no done pulse occurs. start during RUN is ignored.
- With MEM_SWEEP_ERR_CNT_EN: three corrupted words give err_count=3. Start with all of 256 words wrong gives err_count=256.
